// File: rtl/video_ctrl_pkg.sv
// rtl/video_ctrl_pkg.sv - shared types and defaults for the video mode controller
package video_ctrl_pkg;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } video_state_e;

   localparam logic [1:0] SL_NONE = 2'b00;
   localparam logic [1:0] SL_25   = 2'b01;
   localparam logic [1:0] SL_50   = 2'b10;
   localparam logic [1:0] SL_75   = 2'b11;

   localparam int unsigned DIV_W = 2;

   localparam logic [11:0] DEF_LINE_31K_MAX  = 12'd1000;
   localparam logic [3:0]  DEF_LEN_TOL       = 4'd2;
   localparam logic [2:0]  DEF_STABLE_FRAMES = 3'd4;

endpackage

// File: rtl/video_ce_gen.sv
// rtl/video_ce_gen.sv - sync edge detection and hsync-phase-locked pixel enables
module video_ce_gen
   import video_ctrl_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic hsync_i,
   input  logic vsync_i,
   input  logic ce_divider_i,
   output logic hs_fall_o,
   output logic vs_fall_o,
   output logic ce_x1_o,
   output logic ce_x2_o
);

   logic             hs_q, vs_q;
   logic             hs_fall_q, vs_fall_q;
   logic             hs_fall_d, vs_fall_d;
   logic [DIV_W-1:0] i_div_q, i_div_d;

   // The divider restarts together with the registered fall pulse, so it reads 0 in that cycle.
   always_comb begin
      hs_fall_d = hs_q & ~hsync_i;
      vs_fall_d = vs_q & ~vsync_i;
      i_div_d   = hs_fall_d ? '0 : i_div_q + DIV_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         hs_q      <= 1'b0;
         vs_q      <= 1'b0;
         hs_fall_q <= 1'b0;
         vs_fall_q <= 1'b0;
         i_div_q   <= '0;
      end else begin
         hs_q      <= hsync_i;
         vs_q      <= vsync_i;
         hs_fall_q <= hs_fall_d;
         vs_fall_q <= vs_fall_d;
         i_div_q   <= i_div_d;
      end
   end

   always_comb begin
      if (ce_divider_i) begin
         ce_x1_o = i_div_q[0];
         ce_x2_o = 1'b1;
      end else begin
         ce_x1_o = (i_div_q == DIV_W'(1));
         ce_x2_o = i_div_q[0];
      end
   end

   assign hs_fall_o = hs_fall_q;
   assign vs_fall_o = vs_fall_q;

endmodule

// File: rtl/video_mode_ctrl.sv
// rtl/video_mode_ctrl.sv - measures line/frame timing, locks a video mode, applies scandoubler config at frame boundaries
module video_mode_ctrl
   import video_ctrl_pkg::*;
#(
   parameter int unsigned           HCNT_WIDTH    = 12,
   parameter int unsigned           LCNT_WIDTH    = 10,
   parameter logic [HCNT_WIDTH-1:0] LINE_31K_MAX  = HCNT_WIDTH'(DEF_LINE_31K_MAX),
   parameter logic [3:0]            LEN_TOL       = DEF_LEN_TOL,
   parameter logic [2:0]            STABLE_FRAMES = DEF_STABLE_FRAMES
) (
   input  logic                  clk_sys,
   input  logic                  reset_n,
   input  logic                  HSync,
   input  logic                  VSync,
   input  logic                  ce_divider,
   input  logic [1:0]            scanlines_req,
   input  logic                  sd_force_off,
   output logic                  ce_x1,
   output logic                  ce_x2,
   output logic [1:0]            scanlines,
   output logic                  scandoubler_disable,
   output logic [HCNT_WIDTH-1:0] line_len,
   output logic [LCNT_WIDTH-1:0] lines_per_frame,
   output logic                  mode_valid,
   output logic                  mode_changed
);

   video_state_e           state_q;
   logic                   hs_fall, vs_fall;
   logic [HCNT_WIDTH-1:0]  hcnt_q, ref_len_q, prev_ref_q, line_len_q;
   logic [HCNT_WIDTH-1:0]  new_len, frame_ref;
   logic [LCNT_WIDTH-1:0]  lcnt_q, prev_lines_q, lines_q;
   logic [LCNT_WIDTH-1:0]  lcnt_inc, frame_lines;
   logic [2:0]             stable_q, stable_inc;
   logic                   first_q, bad_q, valid_q, changed_q, sd_dis_q;
   logic [1:0]             sl_q;
   logic signed [HCNT_WIDTH:0] line_diff, ref_diff;
   logic [HCNT_WIDTH:0]    line_mag, ref_mag;
   logic                   line_ok, ref_ok, frame_bad, frame_match, timeout, target_sd;

   video_ce_gen u_ce_gen (
      .clk_i        (clk_sys),
      .rst_ni       (reset_n),
      .hsync_i      (HSync),
      .vsync_i      (VSync),
      .ce_divider_i (ce_divider),
      .hs_fall_o    (hs_fall),
      .vs_fall_o    (vs_fall),
      .ce_x1_o      (ce_x1),
      .ce_x2_o      (ce_x2)
   );

   // frame_* include a line ending in the same cycle as the frame, so it counts into the closing frame.
   always_comb begin
      new_len     = hcnt_q + HCNT_WIDTH'(1);
      lcnt_inc    = (lcnt_q == '1) ? lcnt_q : lcnt_q + LCNT_WIDTH'(1);
      frame_lines = hs_fall ? lcnt_inc : lcnt_q;
      frame_ref   = (hs_fall && first_q) ? new_len : ref_len_q;
      line_diff   = $signed({1'b0, new_len}) - $signed({1'b0, ref_len_q});
      line_mag    = line_diff[HCNT_WIDTH] ? $unsigned(-line_diff) : $unsigned(line_diff);
      line_ok     = line_mag <= (HCNT_WIDTH+1)'(LEN_TOL);
      ref_diff    = $signed({1'b0, frame_ref}) - $signed({1'b0, prev_ref_q});
      ref_mag     = ref_diff[HCNT_WIDTH] ? $unsigned(-ref_diff) : $unsigned(ref_diff);
      ref_ok      = ref_mag <= (HCNT_WIDTH+1)'(LEN_TOL);
      frame_bad   = bad_q | (hs_fall & ~first_q & ~line_ok);
      frame_match = ~frame_bad & (frame_lines == prev_lines_q) & ref_ok;
      timeout     = (hcnt_q == '1) | (lcnt_q == '1);
      stable_inc  = stable_q + 3'd1;
      target_sd   = sd_force_off | (valid_q & (line_len_q <= LINE_31K_MAX));
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state_q      <= SEARCH;
         hcnt_q       <= '0;
         lcnt_q       <= '0;
         ref_len_q    <= '0;
         prev_ref_q   <= '0;
         prev_lines_q <= '0;
         line_len_q   <= '0;
         lines_q      <= '0;
         stable_q     <= '0;
         first_q      <= 1'b0;
         bad_q        <= 1'b0;
         valid_q      <= 1'b0;
         changed_q    <= 1'b0;
         sd_dis_q     <= 1'b0;
         sl_q         <= SL_NONE;
      end else begin
         changed_q <= 1'b0;

         if (hs_fall)
            hcnt_q <= '0;
         else if (hcnt_q != '1)
            hcnt_q <= hcnt_q + HCNT_WIDTH'(1);

         if (vs_fall)
            lcnt_q <= '0;
         else if (hs_fall)
            lcnt_q <= lcnt_inc;

         if (hs_fall) begin
            if (first_q) begin
               ref_len_q <= new_len;
               first_q   <= 1'b0;
            end else if (!line_ok) begin
               bad_q <= 1'b1;
            end
         end

         if (vs_fall) begin
            first_q      <= 1'b1;
            bad_q        <= 1'b0;
            prev_lines_q <= frame_lines;
            prev_ref_q   <= frame_ref;
         end

         if (timeout) begin
            state_q  <= SEARCH;
            valid_q  <= 1'b0;
            stable_q <= '0;
         end else begin
            case (state_q)
               SEARCH: begin
                  if (vs_fall) begin
                     state_q  <= MEASURE;
                     stable_q <= '0;
                  end
               end
               MEASURE: begin
                  if (vs_fall) begin
                     if (frame_match) begin
                        stable_q <= stable_inc;
                        if (stable_inc >= STABLE_FRAMES) begin
                           state_q    <= LOCKED;
                           line_len_q <= frame_ref;
                           lines_q    <= frame_lines;
                           valid_q    <= 1'b1;
                           changed_q  <= 1'b1;
                        end
                     end else begin
                        stable_q <= 3'd1;
                     end
                  end
               end
               LOCKED: begin
                  if (vs_fall && !frame_match) begin
                     state_q  <= MEASURE;
                     stable_q <= 3'd1;
                     valid_q  <= 1'b0;
                  end
               end
               default: state_q <= SEARCH;
            endcase
         end

         // With no frame in flight there is nothing to tear, so SEARCH follows requests immediately.
         if (vs_fall || state_q == SEARCH) begin
            sl_q     <= scanlines_req;
            sd_dis_q <= target_sd;
         end
      end
   end

   assign scanlines           = sl_q;
   assign scandoubler_disable = sd_dis_q;
   assign line_len            = line_len_q;
   assign lines_per_frame     = lines_q;
   assign mode_valid          = valid_q;
   assign mode_changed        = changed_q;

endmodule

// File: doc/video_mode_ctrl.md
Name: video_mode_ctrl

Overview:
- Controller for the video output pipeline (scandoubler plus pixel-enable generation).
- Measures incoming line period and lines per frame in clk_sys cycles, and locks onto a stable video mode.
- Drives scandoubler_disable and scanlines so that changes take effect only at frame boundaries.
- Generates the hsync-phase-locked ce_x1/ce_x2 pixel enables consumed by the scandoubler.

Parameters:
- HCNT_WIDTH, 12: width of the line-period counter and of line_len.
- LCNT_WIDTH, 10: width of the line-per-frame counter and of lines_per_frame.
- LINE_31K_MAX, 12'd1000: a measured line_len at or below this value classifies the source as 31 kHz.
- LEN_TOL, 4'd2: allowed ± cycle deviation of line_len frame to frame.
- STABLE_FRAMES, 3'd4: consecutive matching frames required to lock.

Ports:
- clk_sys  in  1  master clock, 2x or 4x pixel clock.
- reset_n  in  1  synchronous reset, active-low.
- HSync  in  1  source hsync, active-low; the line starts at the falling edge.
- VSync  in  1  source vsync, active-low; the frame starts at the falling edge.
- ce_divider  in  1  0: pixel = clk_sys/4; 1: pixel = clk_sys/2.
- scanlines_req  in  2  requested scanline level: 00 none, 01 25%, 10 50%, 11 75%.
- sd_force_off  in  1  user forces 15 kHz passthrough.
- ce_x1  out  1  source pixel enable.
- ce_x2  out  1  doubled pixel enable.
- scanlines  out  2  applied scanline level.
- scandoubler_disable  out  1  applied bypass select.
- line_len  out  HCNT_WIDTH  locked line period in cycles.
- lines_per_frame  out  LCNT_WIDTH  locked line count.
- mode_valid  out  1  high while LOCKED.
- mode_changed  out  1  one-cycle pulse on every LOCKED entry.

Behaviour:
- Reset (reset_n low at a clk_sys edge):
  - State=SEARCH; all counters 0; i_div=0.
  - Outputs: scanlines=00, scandoubler_disable=0, line_len=0, lines_per_frame=0, mode_valid=0, mode_changed=0.
  - Reset asserted mid-frame aborts the measurement; the block restarts in SEARCH.
- Edge detection:
  - HSync and VSync are registered once.
  - hs_fall = prev & ~cur; vs_fall likewise.
  - Detection occurs one cycle after the pin changes.
- Pixel enable generation:
  - i_div (2-bit) is set to 0 on hs_fall; otherwise it increments and wraps from 3 to 0.
  - ce_divider=0: ce_x1 = (i_div==1), ce_x2 = i_div[0].
  - ce_divider=1: ce_x1 = i_div[0], ce_x2 = 1.
  - ce outputs are combinational from i_div.
  - Generation is active in all states.
- Line measurement:
  - hcnt is cleared on hs_fall, increments otherwise, and saturates at all-ones.
  - On hs_fall: cur_len = hcnt+1; lcnt increments and saturates.
- Frame close:
  - On vs_fall: cur_lines = lcnt; lcnt is cleared.
  - If hs_fall and vs_fall coincide, the line is counted into the closing frame first.
- Timeout: hcnt or lcnt saturating forces SEARCH, drops mode_valid, and clears stable_cnt.
- State machine:
  - SEARCH:
    - Wait for vs_fall, then go to MEASURE with stable_cnt=0.
  - MEASURE:
    - ref_len = cur_len of the first line after vs_fall.
    - Every later line in the frame must satisfy |cur_len - ref_len| <= LEN_TOL; any violation marks the frame bad.
    - At vs_fall, the frame matches if it is not bad, cur_lines equals the previous frame's cur_lines, and ref_len is within LEN_TOL of the previous frame's ref_len.
    - A match increments stable_cnt; a mismatch sets stable_cnt=1, since the new frame becomes the comparison base.
    - When stable_cnt reaches STABLE_FRAMES, go to LOCKED.
    - On LOCKED entry: latch line_len=ref_len and lines_per_frame=cur_lines; set mode_valid=1; pulse mode_changed for 1 cycle.
  - LOCKED:
    - The same per-frame check runs.
    - A mismatch returns to MEASURE with stable_cnt=1 and mode_valid=0.
    - line_len and lines_per_frame hold their last locked values.
- Config apply:
  - Shadow values: target_sd_dis = sd_force_off | (mode_valid & line_len <= LINE_31K_MAX); target scanlines = scanlines_req.
  - Transfer to outputs happens only on the cycle after vs_fall.
  - Exception: in SEARCH, transfer happens every cycle, because no frame is in flight.
  - Changes to the request inputs mid-frame must not alter the outputs before the next vs_fall.
- Arithmetic:
  - Differences are computed in HCNT_WIDTH+1 bits, signed, to avoid wrap.
  - Comparisons against LEN_TOL are unsigned magnitude.

Decomposition:
- Package video_ctrl_pkg:
  - State enum {SEARCH, MEASURE, LOCKED}.
  - Scanline level constants (SL_NONE, SL_25, SL_50, SL_75).
  - Default values for LINE_31K_MAX, LEN_TOL, STABLE_FRAMES.
- Sub-module video_ce_gen: edge detect plus i_div/ce_x1/ce_x2 logic. Its hs_fall output is reused by the measurement logic.

Test Plan:
- Reset, then HSync period 1364 with 262 lines/frame, 5 frames:
  - mode_valid rises at the vs_fall closing frame 4 (the first frame only seeds MEASURE).
  - line_len=1364, lines_per_frame=262, mode_changed is a single 1-cycle pulse.
  - scandoubler_disable=0.
- Period 682 with 525 lines, 5 frames: lock with line_len=682; scandoubler_disable=1 applied only the cycle after the next vs_fall.
- Locked at 1364, then one line of 1370 (outside ±2): mode_valid=0 at that frame's vs_fall and state=MEASURE; relock after 3 further good frames.
- scanlines_req changed 00→10 mid-frame: scanlines stays 00 until the cycle after the next vs_fall, then becomes 10.
- ce_divider=0, observing 8 cycles after hs_fall: ce_x1 high on cycles 2 and 6 only; ce_x2 high on cycles 2, 4, 6, 8 (cycle 1 = the cycle hs_fall is detected).
- HSync held high for 4096 cycles: hcnt saturates, state=SEARCH, mode_valid=0. Assert reset_n low mid-frame: all outputs return to their reset values on the next clk_sys edge.
